tl_xbar_demux: RTL and testbench

//  Downstream stage of the crossbar round-robin arbiter (tl_arbiter): takes its single granted beat

---
 rtl/tl_xbar_pkg.sv | 17 +
 rtl/tl_skid_buf.sv | 62 ++++++
 rtl/tl_xbar_demux.sv | 123 ++++++++++++
 tb/tb_tl_xbar_demux.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tl_xbar_pkg.sv
// Shared types and defaults for the crossbar demux slice.
// Beat tag layout inside the skid buffer, msb..lsb: {sel, last, data}.
package tl_xbar_pkg;

  localparam int SEL_W_DEF   = 2;
  localparam int BEATS_W_DEF = 3;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } route_state_e;

  function automatic int tag_width(input int sel_w, input int data_w);
    return sel_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// One output register plus one skid entry; full throughput with registered outputs.
module tl_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire, out_free;

  assign ready_o  = ~skid_valid_q;
  assign valid_o  = out_valid_q;
  assign data_o   = out_data_q;
  assign in_fire  = valid_i & ~skid_valid_q;
  assign out_free = ~out_valid_q | ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      // A full skid always drains first; input is blocked that cycle by ready_o.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_data_d = data_i;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/tl_xbar_demux.sv
// Routes the arbiter's granted beat stream to one of M sinks by address decode,
// locking the route for the whole message.
//   state   | meaning
//   ST_HEAD | next accepted beat is a message head: decode sel, load beat counter
//   ST_BODY | beats follow latched sel; counter counts down to the last beat
module tl_xbar_demux
  import tl_xbar_pkg::*;
#(
  parameter int M       = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int SEL_LSB = 4,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int BEATS_W = BEATS_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [BEATS_W-1:0] beats_i,
  output logic [M-1:0]       valid_o,
  input  logic [M-1:0]       ready_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               last_o,
  output logic               err_o
);

  localparam int TAG_W = tag_width(SEL_W, DATA_W);

  route_state_e       state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [BEATS_W-1:0] rem_q, rem_d;
  logic               err_q, err_d;

  logic               in_fire, out_fire, buf_ready, out_valid, out_last;
  logic               beat_last, out_of_range;
  logic [SEL_W-1:0]   sel_raw, beat_sel, out_sel;
  logic [DATA_W-1:0]  out_data;
  logic [TAG_W-1:0]   in_tag, out_tag;
  logic               unused_addr;

  assign ready_o      = buf_ready;
  assign in_fire      = valid_i & buf_ready;
  assign sel_raw      = addr_i[SEL_LSB +: SEL_W];
  assign out_of_range = (32'(sel_raw) >= 32'(M));
  assign unused_addr  = ^addr_i;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    err_d     = 1'b0;
    beat_sel  = sel_q;
    beat_last = 1'b0;
    unique case (state_q)
      ST_HEAD: begin
        beat_sel  = out_of_range ? SEL_W'(M - 1) : sel_raw;
        beat_last = (beats_i == '0);
        if (in_fire) begin
          sel_d = beat_sel;
          rem_d = beats_i;
          err_d = out_of_range;
          if (beats_i != '0) state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        beat_last = (rem_q == BEATS_W'(1));
        if (in_fire) begin
          rem_d = rem_q - BEATS_W'(1);
          if (beat_last) state_d = ST_HEAD;
        end
      end
      default: state_d = ST_HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HEAD;
      sel_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Decode happens before buffering so the output stage only carries a tag.
  assign in_tag = {beat_sel, beat_last, data_i};

  tl_skid_buf #(
    .WIDTH(TAG_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .ready_o(buf_ready),
    .data_i (in_tag),
    .valid_o(out_valid),
    .ready_i(out_fire),
    .data_o (out_tag)
  );

  assign out_sel  = out_tag[TAG_W-1 -: SEL_W];
  assign out_last = out_tag[DATA_W];
  assign out_data = out_tag[DATA_W-1:0];

  always_comb begin
    valid_o = '0;
    for (int k = 0; k < M; k++) valid_o[k] = out_valid & (out_sel == SEL_W'(k));
  end

  assign out_fire = |(valid_o & ready_i);
  assign data_o   = out_data;
  assign last_o   = out_last;
  assign err_o    = err_q;

endmodule

// File: tb/tb_tl_xbar_demux.sv
// Directed bench for tl_xbar_demux: M=4 main instance plus an M=3 instance for range errors.
module tb_tl_xbar_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [7:0] data_i, addr_i;
  logic [2:0] beats_i;
  logic [3:0] ready_i;

  logic       ready_o, last_o, err_o;
  logic [3:0] valid_o;
  logic [7:0] data_o;

  logic       ready3_o, last3_o, err3_o;
  logic [2:0] valid3_o;
  logic [7:0] data3_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tl_xbar_demux #(.M(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .addr_i(addr_i), .beats_i(beats_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o), .err_o(err_o)
  );

  tl_xbar_demux #(.M(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready3_o),
    .data_i(data_i), .addr_i(addr_i), .beats_i(beats_i),
    .valid_o(valid3_o), .ready_i(ready_i[2:0]), .data_o(data3_o),
    .last_o(last3_o), .err_o(err3_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    #2;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; addr_i = '0; beats_i = '0; ready_i = 4'hF;
    #12;
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_data",  32'(data_o),  32'h0);
    check("rst_last",  32'(last_o),  32'h0);
    check("rst_err",   32'(err_o),   32'h0);
    check("rst_ready", 32'(ready_o), 32'h1);
    rst_n = 1'b1;

    // 1: single beat to sink 2
    valid_i = 1'b1; addr_i = 8'h25; beats_i = 3'd0; data_i = 8'hA0;
    step();
    check("t1_valid", 32'(valid_o), 32'h4);
    check("t1_data",  32'(data_o),  32'hA0);
    check("t1_last",  32'(last_o),  32'h1);
    check("t1_err",   32'(err_o),   32'h0);
    valid_i = 1'b0;
    step();
    check("t1_idle", 32'(valid_o), 32'h0);

    // 2: 4-beat message locked to sink 1 despite body addr
    valid_i = 1'b1; addr_i = 8'h10; beats_i = 3'd3;
    for (int n = 0; n < 4; n++) begin
      data_i = 8'(8'hA0 + n);
      if (n > 0) addr_i = 8'h30;
      step();
      check("t2_valid", 32'(valid_o), 32'h2);
      check("t2_data",  32'(data_o),  32'(8'hA0 + n));
      check("t2_last",  32'(last_o),  32'(n == 3));
      check("t2_ready", 32'(ready_o), 32'h1);
    end
    valid_i = 1'b0;
    step();
    check("t2_idle", 32'(valid_o), 32'h0);

    // 3: stall fills output + skid, then drains in order
    ready_i = 4'h0; valid_i = 1'b1; addr_i = 8'h00; beats_i = 3'd2; data_i = 8'hA0;
    step();
    check("t3_a0_valid", 32'(valid_o), 32'h1);
    check("t3_a0_ready", 32'(ready_o), 32'h1);
    data_i = 8'hA1;
    step();
    check("t3_skid_ready", 32'(ready_o), 32'h0);
    check("t3_hold_data",  32'(data_o),  32'hA0);
    data_i = 8'hA2;
    step();
    check("t3_stall_ready", 32'(ready_o), 32'h0);
    check("t3_stall_valid", 32'(valid_o), 32'h1);
    check("t3_stall_data",  32'(data_o),  32'hA0);
    ready_i = 4'hF;
    step();
    check("t3_a1_data",  32'(data_o),  32'hA1);
    check("t3_a1_last",  32'(last_o),  32'h0);
    check("t3_a1_ready", 32'(ready_o), 32'h1);
    step();
    check("t3_a2_data",  32'(data_o),  32'hA2);
    check("t3_a2_last",  32'(last_o),  32'h1);
    check("t3_a2_valid", 32'(valid_o), 32'h1);
    valid_i = 1'b0;
    step();
    check("t3_idle", 32'(valid_o), 32'h0);

    // 4: M=3 out-of-range head clamps to sink 2 with a one-cycle err
    pulse_reset();
    valid_i = 1'b1; addr_i = 8'h30; beats_i = 3'd0; data_i = 8'hA0;
    step();
    check("t4_valid3", 32'(valid3_o), 32'h4);
    check("t4_err3",   32'(err3_o),   32'h1);
    check("t4_last3",  32'(last3_o),  32'h1);
    check("t4_valid4", 32'(valid_o),  32'h8);
    check("t4_err4",   32'(err_o),    32'h0);
    addr_i = 8'h20; data_i = 8'hA1;
    step();
    check("t4_inrange_valid3", 32'(valid3_o), 32'h4);
    check("t4_inrange_err3",   32'(err3_o),   32'h0);
    check("t4_inrange_data3",  32'(data3_o),  32'hA1);
    valid_i = 1'b0;
    step();
    check("t4_idle_err3", 32'(err3_o), 32'h0);

    // 5: reset mid-message, next beat is treated as a head
    valid_i = 1'b1; addr_i = 8'h10; beats_i = 3'd3; data_i = 8'hA0;
    step();
    data_i = 8'hA1; addr_i = 8'h30;
    step();
    rst_n = 1'b0; valid_i = 1'b0;
    #1;
    check("t5_rst_valid", 32'(valid_o), 32'h0);
    check("t5_rst_ready", 32'(ready_o), 32'h1);
    check("t5_rst_last",  32'(last_o),  32'h0);
    rst_n = 1'b1;
    valid_i = 1'b1; addr_i = 8'h00; beats_i = 3'd0; data_i = 8'hA2;
    step();
    check("t5_head_valid", 32'(valid_o), 32'h1);
    check("t5_head_data",  32'(data_o),  32'hA2);
    check("t5_head_last",  32'(last_o),  32'h1);
    valid_i = 1'b0;
    step();
    check("t5_idle", 32'(valid_o), 32'h0);

    // 6: back-to-back single beats to sinks 0,3,1 with no bubble
    valid_i = 1'b1; beats_i = 3'd0;
    addr_i = 8'h00; data_i = 8'hA0;
    step();
    check("t6_s0_valid", 32'(valid_o), 32'h1);
    check("t6_s0_data",  32'(data_o),  32'hA0);
    check("t6_s0_ready", 32'(ready_o), 32'h1);
    addr_i = 8'h30; data_i = 8'hA1;
    step();
    check("t6_s3_valid", 32'(valid_o), 32'h8);
    check("t6_s3_data",  32'(data_o),  32'hA1);
    check("t6_s3_ready", 32'(ready_o), 32'h1);
    addr_i = 8'h10; data_i = 8'hA2;
    step();
    check("t6_s1_valid", 32'(valid_o), 32'h2);
    check("t6_s1_data",  32'(data_o),  32'hA2);
    check("t6_s1_last",  32'(last_o),  32'h1);
    valid_i = 1'b0;
    step();
    check("t6_idle", 32'(valid_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
